// File: rtl/andor_sched_pkg.sv
// Shared types for the AndOr time-sharing scheduler and its round-robin helper.
package andor_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of Req at or above Ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  Req,
  input  logic [PW-1:0] Ptr,
  output logic [PW-1:0] Winner,
  output logic          Valid
);

  logic [PW-1:0] cand [N];

  // cand[i] is the requester index i places after the pointer, modulo N
  for (genvar i = 0; i < N; i++) begin : g_cand
    logic [PW:0] sum;
    assign sum     = {1'b0, Ptr} + (PW+1)'(i);
    assign cand[i] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
  end

  always_comb begin
    Valid  = 1'b0;
    Winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (Req[cand[i]]) begin
        Valid  = 1'b1;
        Winner = cand[i];
      end
    end
  end

endmodule

// File: rtl/andor_scheduler.sv
// Time-shares one external AndOr unit among N_REQ requesters: round-robin grant,
// hold operands for SETTLE cycles, then capture X/Y and pulse Done to the owner.
module andor_scheduler
  import andor_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N_REQ-1:0] Req,
  input  logic [N_REQ-1:0] ReqA,
  input  logic [N_REQ-1:0] ReqB,
  input  logic [N_REQ-1:0] ReqC,
  output logic [N_REQ-1:0] Grant,
  output logic [N_REQ-1:0] Done,
  output logic             RespX,
  output logic             RespY,
  output logic             UnitA,
  output logic             UnitB,
  output logic             UnitC,
  input  logic             UnitX,
  input  logic             UnitY,
  output logic             Busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] pick;
  logic          pick_valid;
  logic [CW-1:0] cnt;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .Req    (Req),
    .Ptr    (ptr),
    .Winner (pick),
    .Valid  (pick_valid)
  );

  // Unit operands are only reloaded at grant, so they sit still while idle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      Grant <= '0;
      Done  <= '0;
      RespX <= 1'b0;
      RespY <= 1'b0;
      UnitA <= 1'b0;
      UnitB <= 1'b0;
      UnitC <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      Done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            UnitA <= ReqA[pick];
            UnitB <= ReqB[pick];
            UnitC <= ReqC[pick];
            Grant <= N_REQ'(1) << pick;
            owner <= pick;
            cnt   <= CNT_LOAD;
            Busy  <= 1'b1;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            RespX <= UnitX;
            RespY <= UnitY;
            Done  <= Grant;
            Grant <= '0;
            Busy  <= 1'b0;
            ptr   <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_andor_scheduler.sv
// Scoreboard bench for andor_scheduler with a delayed behavioural AndOr unit.
`timescale 1ns/1ps
module tb_andor_scheduler;

  typedef struct packed {
    logic [3:0] done;
    logic       x;
    logic       y;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req_a, req_b, req_c;
  logic [3:0] grant, done;
  logic       resp_x, resp_y, unit_a, unit_b, unit_c, busy;
  logic       unit_x = 1'b0;
  logic       unit_y = 1'b0;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [3:0] exp_grant[$];
  resp_t      exp_resp[$];
  logic [3:0] prev_grant = '0;
  bit         rr_phase   = 1'b0;
  int         rr_count   = 0;
  int         last_grant_cycle = 0;

  andor_scheduler #(.N_REQ(4), .SETTLE(2)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .Req   (req),
    .ReqA  (req_a),
    .ReqB  (req_b),
    .ReqC  (req_c),
    .Grant (grant),
    .Done  (done),
    .RespX (resp_x),
    .RespY (resp_y),
    .UnitA (unit_a),
    .UnitB (unit_b),
    .UnitC (unit_c),
    .UnitX (unit_x),
    .UnitY (unit_y),
    .Busy  (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycle++;

  // AndOr unit with its 10ns propagation delay: X = A&B, Y = (A&B)|C
  always @(unit_a, unit_b, unit_c) begin
    #10;
    unit_x = unit_a & unit_b;
    unit_y = (unit_a & unit_b) | unit_c;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    req   = r;
    req_a = a;
    req_b = b;
    req_c = c;
  endtask

  task automatic expectOp(input int idx, input bit a, input bit b, input bit c, input bit completes);
    resp_t r;
    exp_grant.push_back(4'b0001 << idx);
    if (completes) begin
      r.done = 4'b0001 << idx;
      r.x    = a & b;
      r.y    = (a & b) | c;
      exp_resp.push_back(r);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, {4'b0, grant}, 8'h00);
    checkOutput({tag, "_done"},  {4'b0, done},  8'h00);
    checkOutput({tag, "_misc"},  {2'b0, resp_x, resp_y, unit_a, unit_b, unit_c, busy}, 8'h00);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a Done
  always @(negedge clk) begin
    checkOutput("done_grant_overlap", {4'b0, done & grant}, 8'h00);
    if (grant != 4'b0 && grant != prev_grant) begin
      if (exp_grant.size() == 0) begin
        checkOutput("unexpected_grant", {4'b0, grant}, 8'h00);
      end else begin
        checkOutput("grant_order", {4'b0, grant}, {4'b0, exp_grant.pop_front()});
      end
      if (rr_phase) begin
        if (rr_count > 0) checkOutput("grant_spacing", 8'(cycle - last_grant_cycle), 8'd3);
        rr_count++;
      end
      last_grant_cycle = cycle;
    end
    prev_grant = grant;
    if (done != 4'b0) begin
      if (exp_resp.size() == 0) begin
        checkOutput("unexpected_done", {4'b0, done}, 8'h00);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        checkOutput("done_owner", {4'b0, done}, {4'b0, r.done});
        checkOutput("resp_x", {7'b0, resp_x}, {7'b0, r.x});
        checkOutput("resp_y", {7'b0, resp_y}, {7'b0, r.y});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: requester 0 with A/B/C = 1/1/0
    $display("[TB] single request");
    expectOp(0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    waitEdge();
    checkOutput("single_grant_e0", {4'b0, grant}, 8'h01);
    checkOutput("single_busy_e0", {7'b0, busy}, 8'h01);
    checkOutput("single_unit_e0", {5'b0, unit_a, unit_b, unit_c}, 8'h06);
    waitEdge();
    checkOutput("single_grant_e1", {4'b0, grant}, 8'h01);
    waitEdge();
    checkOutput("single_grant_e2", {4'b0, grant}, 8'h00);
    checkOutput("single_busy_e2", {7'b0, busy}, 8'h00);

    // Pointer skip: Ptr is 1, so requester 3 wins over requester 0
    $display("[TB] pointer skip");
    expectOp(3, 1'b1, 1'b0, 1'b0, 1'b1);
    expectOp(0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b1001, 4'b1000, 4'b0001, 4'b0001);
    waitEdge();
    checkOutput("skip_first", {4'b0, grant}, 8'h08);
    repeat (2) waitEdge();
    req = 4'b0001;
    waitEdge();
    checkOutput("skip_second", {4'b0, grant}, 8'h01);
    repeat (2) waitEdge();
    req = 4'b0000;

    // Reset pulse returns Ptr to 0 before the round-robin run
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("reset_pulse");
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with all four requesting continuously
    $display("[TB] round robin");
    expectOp(0, 1'b1, 1'b1, 1'b0, 1'b1);
    expectOp(1, 1'b0, 1'b1, 1'b0, 1'b1);
    expectOp(2, 1'b1, 1'b0, 1'b0, 1'b1);
    expectOp(3, 1'b0, 1'b0, 1'b1, 1'b1);
    expectOp(0, 1'b1, 1'b1, 1'b0, 1'b1);
    rr_count = 0;
    rr_phase = 1'b1;
    applyStimulus(4'b1111, 4'b0101, 4'b0011, 4'b1000);
    repeat (15) waitEdge();
    req = 4'b0000;
    rr_phase = 1'b0;
    checkOutput("rr_grant_count", 8'(rr_count), 8'd5);

    // Operand change during DRIVE is ignored
    $display("[TB] operand change");
    expectOp(1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0010);
    waitEdge();
    checkOutput("opchg_grant", {4'b0, grant}, 8'h02);
    applyStimulus(4'b0010, 4'b0010, 4'b0010, 4'b0010);
    waitEdge();
    checkOutput("opchg_unit_held", {5'b0, unit_a, unit_b, unit_c}, 8'h01);
    waitEdge();
    req = 4'b0000;

    // Request dropped during DRIVE still completes
    $display("[TB] request dropped early");
    expectOp(1, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0010);
    waitEdge();
    checkOutput("drop_grant", {4'b0, grant}, 8'h02);
    req = 4'b0000;
    repeat (2) waitEdge();
    repeat (4) begin
      waitEdge();
      checkOutput("drop_no_regrant", {3'b0, busy, grant}, 8'h00);
    end

    // Reset one cycle after grant discards the operation
    $display("[TB] reset mid-operation");
    expectOp(0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    waitEdge();
    checkOutput("midrst_grant", {4'b0, grant}, 8'h01);
    waitEdge();
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expectOp(2, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0100);
    waitEdge();
    checkOutput("postrst_grant", {4'b0, grant}, 8'h04);
    repeat (2) waitEdge();
    req = 4'b0000;
    repeat (3) waitEdge();

    checkOutput("grants_left", 8'(exp_grant.size()), 8'd0);
    checkOutput("resps_left", 8'(exp_resp.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
